// File: rtl/stats_pkg.sv
// Shared types and helpers for the statistics engine: mode and FSM state
// encodings plus a constant-foldable ceil(log2) used for sizing.
package stats_pkg;

    typedef enum logic [1:0] {
        MODE_SUM   = 2'b00,
        MODE_AVG   = 2'b01,
        MODE_SUMSQ = 2'b10,
        MODE_STD   = 2'b11
    } mode_e;

    typedef enum logic [3:0] {
        IDLE,
        LOADN,
        LOADS,
        READY,
        ACCUM,
        DIV,
        VAR,
        SQRT,
        DONE
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stats_isqrt.sv
// Bit-serial integer square root: one result bit per cycle, MSB first,
// keeping a bit only if the trial root squared still fits under the radicand.
module stats_isqrt
    import stats_pkg::*;
#(
    parameter int  RW = 14,
    localparam int HW = (RW + 1) / 2,
    localparam int BW = (clog2(HW) < 1) ? 1 : clog2(HW)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [RW-1:0] radicand_i,
    output logic          done_o,
    output logic [HW-1:0] root_o
);

    logic            run_q, run_d;
    logic            done_q, done_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [RW-1:0]   x_q, x_d;
    logic [HW-1:0]   root_q, root_d;
    logic [HW-1:0]   trial;
    logic [2*HW-1:0] trial_w;
    logic [2*HW-1:0] trial_sq;
    logic            fits;

    assign trial    = root_q | (HW'(1) << bit_q);
    assign trial_w  = (2*HW)'(trial);
    assign trial_sq = trial_w * trial_w;
    assign fits     = trial_sq <= (2*HW)'(x_q);

    always_comb begin
        run_d  = run_q;
        done_d = 1'b0;
        bit_d  = bit_q;
        x_d    = x_q;
        root_d = root_q;
        if (start_i) begin
            run_d  = 1'b1;
            bit_d  = BW'(HW - 1);
            x_d    = radicand_i;
            root_d = '0;
        end else if (run_q) begin
            if (fits) root_d = trial;
            if (bit_q == '0) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                bit_d = bit_q - BW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            bit_q  <= '0;
        end else begin
            run_q  <= run_d;
            done_q <= done_d;
            bit_q  <= bit_d;
        end
    end

    always_ff @(posedge clk_i) begin
        x_q    <= x_d;
        root_q <= root_d;
    end

    assign done_o = done_q;
    assign root_o = root_q;

endmodule

// File: rtl/stats_engine.sv
// Sample loader and statistics engine: sum, average, sum of squares and
// standard deviation over up to DEPTH samples, result read out bytewise.
module stats_engine
    import stats_pkg::*;
#(
    parameter int  W     = 5,
    parameter int  DEPTH = 10,
    localparam int RW    = 2 * W + clog2(DEPTH),
    localparam int NB    = (RW + 7) / 8,
    localparam int BSW   = (clog2(NB) < 1) ? 1 : clog2(NB)
) (
    input  logic           myClock,
    input  logic           RESET,
    input  logic           load,
    input  logic [W-1:0]   din,
    input  logic           clear,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic [BSW-1:0] byte_sel,
    output logic [7:0]     dout,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int IW = clog2(DEPTH + 1);
    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(RW);
    localparam int HW = (RW + 1) / 2;

    state_e          state_q, state_d;
    mode_e           mode_q, mode_d;
    logic [IW-1:0]   n_q, n_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   result_q, result_d;

    logic [W-1:0]    sample_q [DEPTH];
    logic [RW-1:0]   sum_q, sum_d;
    logic [RW-1:0]   sumsq_q, sumsq_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [RW-1:0]   quo_q, quo_d;
    logic [W-1:0]    avg_q, avg_d;

    logic            samp_we;
    logic            n_ok;
    logic [W-1:0]    cur_x;
    logic [RW-1:0]   x_ext;
    logic [RW-1:0]   x_sq;
    logic signed [W:0] dev_s;
    logic [W:0]      dev_mag;
    logic [RW-1:0]   dev_sq;
    logic [RW:0]     rem_sh;
    logic [RW:0]     n_ext;
    logic            div_ge;
    logic [RW-1:0]   div_rem;
    logic [RW-1:0]   div_quo;
    logic            div_last;
    logic            sq_start;
    logic            sq_done;
    logic [HW-1:0]   sq_root;
    logic [8*NB-1:0] res_pad;

    assign n_ok    = (din != '0) && (32'(din) <= 32'(DEPTH));
    assign cur_x   = sample_q[idx_q[AW-1:0]];
    assign x_ext   = RW'(cur_x);
    assign x_sq    = x_ext * x_ext;

    // Deviation from the floored mean, squared; signed so |x-avg| is exact.
    assign dev_s   = $signed({1'b0, cur_x}) - $signed({1'b0, avg_q});
    assign dev_mag = (dev_s < 0) ? $unsigned(-dev_s) : $unsigned(dev_s);
    assign dev_sq  = RW'(dev_mag) * RW'(dev_mag);

    // Restoring divider step, shared by the mean and variance divisions.
    assign rem_sh   = {rem_q, quo_q[RW-1]};
    assign n_ext    = (RW+1)'(n_q);
    assign div_ge   = rem_sh >= n_ext;
    assign div_rem  = div_ge ? RW'(rem_sh - n_ext) : RW'(rem_sh);
    assign div_quo  = {quo_q[RW-2:0], div_ge};
    assign div_last = cnt_q == CW'(RW - 1);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        n_d      = n_q;
        idx_d    = idx_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = done_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        sum_d    = sum_q;
        sumsq_d  = sumsq_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        avg_d    = avg_q;
        samp_we  = 1'b0;
        sq_start = 1'b0;

        case (state_q)
            IDLE, LOADN: begin
                if (start) err_d = 1'b1;
                if (load) begin
                    if (n_ok) begin
                        n_d     = IW'(din);
                        idx_d   = '0;
                        state_d = LOADS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = LOADN;
                    end
                end
            end
            LOADS: begin
                if (start) err_d = 1'b1;
                if (load) begin
                    samp_we = 1'b1;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q + IW'(1) == n_q) state_d = READY;
                end
            end
            READY, DONE: begin
                if (start) begin
                    state_d = ACCUM;
                    mode_d  = mode_e'(mode);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    idx_d   = '0;
                    sum_d   = '0;
                    sumsq_d = '0;
                end
            end
            ACCUM: begin
                if (idx_q < n_q) begin
                    sum_d   = sum_q + x_ext;
                    sumsq_d = sumsq_q + x_sq;
                    idx_d   = idx_q + IW'(1);
                end else if (mode_q == MODE_SUM || mode_q == MODE_SUMSQ) begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = (mode_q == MODE_SUM) ? sum_q : sumsq_q;
                end else begin
                    state_d = DIV;
                    phase_d = 1'b0;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = sum_q;
                end
            end
            DIV: begin
                rem_d = div_rem;
                quo_d = div_quo;
                cnt_d = cnt_q + CW'(1);
                if (div_last) begin
                    if (!phase_q) begin
                        avg_d = div_quo[W-1:0];
                        if (mode_q == MODE_AVG) begin
                            state_d  = DONE;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                            result_d = div_quo;
                        end else begin
                            state_d = VAR;
                            idx_d   = '0;
                            sumsq_d = '0;
                        end
                    end else begin
                        sq_start = 1'b1;
                        state_d  = SQRT;
                    end
                end
            end
            VAR: begin
                if (idx_q < n_q) begin
                    sumsq_d = sumsq_q + dev_sq;
                    idx_d   = idx_q + IW'(1);
                end else begin
                    state_d = DIV;
                    phase_d = 1'b1;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = sumsq_q;
                end
            end
            SQRT: begin
                if (sq_done) begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = RW'(sq_root);
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over every other request, but never interrupts a computation.
        if (clear && !busy_q) begin
            state_d = LOADN;
            n_d     = '0;
            idx_d   = '0;
            err_d   = 1'b0;
            done_d  = 1'b0;
            busy_d  = 1'b0;
            samp_we = 1'b0;
        end
    end

    always_ff @(posedge myClock or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            mode_q   <= MODE_SUM;
            n_q      <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            phase_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge myClock) begin
        sum_q   <= sum_d;
        sumsq_q <= sumsq_d;
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        avg_q   <= avg_d;
        if (samp_we) sample_q[idx_q[AW-1:0]] <= din;
    end

    stats_isqrt #(.RW(RW)) u_isqrt (
        .clk_i      (myClock),
        .rst_i      (RESET),
        .start_i    (sq_start),
        .radicand_i (div_quo),
        .done_o     (sq_done),
        .root_o     (sq_root)
    );

    assign res_pad = (8*NB)'(result_q);

    always_comb begin
        dout = 8'h00;
        if (32'(byte_sel) < 32'(NB)) dout = 8'(res_pad >> {byte_sel, 3'b000});
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_stats_engine.sv
// Scoreboard bench for stats_engine: a default-sized instance and a
// W=8/DEPTH=64 instance, each with its own expected-result queue and monitor.
module tb_stats_engine;

    localparam int NB_A  = 2;
    localparam int BSW_A = 1;
    localparam int NB_B  = 3;
    localparam int BSW_B = 2;

    typedef struct {
        logic [31:0] val;
        int          lat;
        string       name;
    } exp_t;

    logic clk;
    logic rst_a, load_a, clear_a, start_a, busy_a, done_a, err_a;
    logic [4:0] din_a;
    logic [1:0] mode_a;
    logic [BSW_A-1:0] bsel_a;
    logic [7:0] dout_a;

    logic rst_b, load_b, clear_b, start_b, busy_b, done_b, err_b;
    logic [7:0] din_b;
    logic [1:0] mode_b;
    logic [BSW_B-1:0] bsel_b;
    logic [7:0] dout_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int a_start = 0;
    int b_start = 0;

    stats_engine dut_a (
        .myClock(clk), .RESET(rst_a), .load(load_a), .din(din_a), .clear(clear_a),
        .start(start_a), .mode(mode_a), .byte_sel(bsel_a), .dout(dout_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    stats_engine #(.W(8), .DEPTH(64)) dut_b (
        .myClock(clk), .RESET(rst_b), .load(load_b), .din(din_b), .clear(clear_b),
        .start(start_b), .mode(mode_b), .byte_sel(bsel_b), .dout(dout_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, got, got, exp, exp);
        end
    endtask

    task automatic a_load(input logic [4:0] v);
        @(negedge clk);
        load_a = 1'b1;
        din_a  = v;
        @(negedge clk);
        load_a = 1'b0;
    endtask

    task automatic a_clear();
        @(negedge clk);
        clear_a = 1'b1;
        @(negedge clk);
        clear_a = 1'b0;
    endtask

    task automatic a_run(input logic [1:0] m, input logic [31:0] v, input int lat,
                         input string nm, input bit disturb);
        exp_t e;
        e.val  = v;
        e.lat  = lat;
        e.name = nm;
        @(negedge clk);
        mode_a  = m;
        start_a = 1'b1;
        a_start = cyc;
        q_a.push_back(e);
        @(negedge clk);
        start_a = 1'b0;
        chk({nm, "_busy"}, 32'(busy_a), 1);
        if (disturb) begin
            start_a = 1'b1;
            mode_a  = ~m;
            @(negedge clk);
            start_a = 1'b0;
        end
        for (int i = 0; i < 400 && !done_a; i++) @(negedge clk);
        chk({nm, "_done"}, 32'(done_a), 1);
        @(negedge clk);
    endtask

    task automatic b_load(input logic [7:0] v);
        @(negedge clk);
        load_b = 1'b1;
        din_b  = v;
        @(negedge clk);
        load_b = 1'b0;
    endtask

    task automatic b_run(input logic [1:0] m, input logic [31:0] v, input int lat, input string nm);
        exp_t e;
        e.val  = v;
        e.lat  = lat;
        e.name = nm;
        @(negedge clk);
        mode_b  = m;
        start_b = 1'b1;
        b_start = cyc;
        q_b.push_back(e);
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 400 && !done_b; i++) @(negedge clk);
        chk({nm, "_done"}, 32'(done_b), 1);
        @(negedge clk);
    endtask

    // Monitor A: on each rising done, read all result bytes and score them.
    initial begin
        logic prev;
        logic [31:0] got;
        exp_t e;
        prev   = 1'b0;
        bsel_a = '0;
        forever begin
            @(negedge clk);
            if (done_a && !prev) begin
                got = '0;
                for (int k = 0; k < NB_A; k++) begin
                    bsel_a = BSW_A'(k);
                    #1;
                    got[8*k +: 8] = dout_a;
                end
                bsel_a = '0;
                if (q_a.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mon_a: unexpected done with result %0d, expected no result", got);
                end else begin
                    e = q_a.pop_front();
                    chk({e.name, "_result"}, got, e.val);
                    if (e.lat >= 0) chk({e.name, "_latency"}, 32'(cyc - a_start), 32'(e.lat));
                end
            end
            prev = done_a;
        end
    end

    // Monitor B: same, plus an out-of-range byte select must read zero.
    initial begin
        logic prev;
        logic [31:0] got;
        exp_t e;
        prev   = 1'b0;
        bsel_b = '0;
        forever begin
            @(negedge clk);
            if (done_b && !prev) begin
                got = '0;
                for (int k = 0; k < NB_B; k++) begin
                    bsel_b = BSW_B'(k);
                    #1;
                    got[8*k +: 8] = dout_b;
                end
                bsel_b = BSW_B'(NB_B);
                #1;
                chk("b_bsel_nb", 32'(dout_b), 0);
                bsel_b = '0;
                if (q_b.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mon_b: unexpected done with result %0d, expected no result", got);
                end else begin
                    e = q_b.pop_front();
                    chk({e.name, "_result"}, got, e.val);
                    if (e.lat >= 0) chk({e.name, "_latency"}, 32'(cyc - b_start), 32'(e.lat));
                end
            end
            prev = done_b;
        end
    end

    initial begin
        rst_a = 1'b1; load_a = 1'b0; clear_a = 1'b0; start_a = 1'b0; din_a = '0; mode_a = '0;
        rst_b = 1'b1; load_b = 1'b0; clear_b = 1'b0; start_b = 1'b0; din_b = '0; mode_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_err",  32'(err_a),  0);
        chk("rst_dout", 32'(dout_a), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        a_load(5'd0);
        chk("n0_err", 32'(err_a), 1);
        a_clear();
        chk("clear_err", 32'(err_a), 0);
        a_load(5'd11);
        chk("n11_err", 32'(err_a), 1);
        a_clear();
        a_load(5'd4);
        a_load(5'd1);
        a_load(5'd2);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("early_start_err", 32'(err_a), 1);
        @(negedge clk);
        chk("early_start_busy", 32'(busy_a), 0);
        a_clear();
        chk("reclear_err", 32'(err_a), 0);

        a_load(5'd4);
        for (int i = 1; i <= 4; i++) a_load(5'(i));
        chk("loaded_err", 32'(err_a), 0);
        a_run(2'b00, 32'd10, 6,  "a4_sum", 1'b1);
        a_run(2'b01, 32'd2,  -1, "a4_avg", 1'b0);
        a_run(2'b10, 32'd30, -1, "a4_sumsq", 1'b0);
        a_run(2'b11, 32'd1,  -1, "a4_std", 1'b0);

        @(negedge clk);
        mode_a  = 2'b11;
        start_a = 1'b1;
        a_start = cyc;
        @(negedge clk);
        start_a = 1'b0;
        while (cyc - a_start < 42) @(negedge clk);
        chk("sqrt_busy", 32'(busy_a), 1);
        rst_a = 1'b1;
        #1;
        chk("sqrt_rst_busy", 32'(busy_a), 0);
        chk("sqrt_rst_done", 32'(done_a), 0);
        chk("sqrt_rst_dout", 32'(dout_a), 0);
        @(negedge clk);
        rst_a = 1'b0;

        a_load(5'd4);
        for (int i = 1; i <= 4; i++) a_load(5'(i));
        a_run(2'b00, 32'd10, 6,  "r4_sum", 1'b0);
        a_run(2'b01, 32'd2,  -1, "r4_avg", 1'b0);
        a_run(2'b10, 32'd30, -1, "r4_sumsq", 1'b0);
        a_run(2'b11, 32'd1,  -1, "r4_std", 1'b0);

        a_clear();
        chk("clear_done", 32'(done_a), 0);
        chk("result_held", 32'(dout_a), 1);

        a_load(5'd10);
        for (int i = 0; i < 10; i++) a_load(5'd31);
        a_run(2'b00, 32'd310,  12, "a10_sum", 1'b0);
        a_run(2'b10, 32'd9610, -1, "a10_sumsq", 1'b0);
        a_run(2'b11, 32'd0,    -1, "a10_std", 1'b0);

        b_load(8'd64);
        for (int i = 0; i < 64; i++) b_load(8'd255);
        b_run(2'b00, 32'd16320, 66, "b64_sum");
        b_run(2'b01, 32'd255,   -1, "b64_avg");
        b_run(2'b11, 32'd0,     -1, "b64_std");

        for (int i = 0; i < 10 && (q_a.size() + q_b.size()) != 0; i++) @(negedge clk);
        chk("scoreboard_empty", 32'(q_a.size() + q_b.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stats_engine.md
STATS_ENGINE -- requirements
Module: stats_engine

Interface
REQ-001 SHALL have parameter W, default 5, meaning sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 10, meaning max samples held (2..64).
REQ-003 SHALL derive localparam RW = 2*W + clog2(DEPTH), meaning result width; NB = ceil(RW/8), meaning number of result bytes.
REQ-004 SHALL have ports: myClock  in  1  sole clock; RESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: load  in  1  single-cycle strobe, already debounced; din  in  W  count or sample value.
REQ-006 SHALL have ports: clear  in  1  restart loading; start  in  1  single-cycle compute request; mode  in  2  00 sum, 01 average, 10 sum of squares, 11 std deviation.
REQ-007 SHALL have ports: byte_sel  in  clog2(NB) (min 1)  result byte index; dout  out  8  selected result byte; busy  out  1; done  out  1; err  out  1.

Function
REQ-008 SHALL run FSM states IDLE, LOADN, LOADS, READY, ACCUM, DIV, VAR, SQRT, DONE.
REQ-009 In IDLE/LOADN, a load SHALL capture din as n; 1<=n<=DEPTH goes to LOADS; otherwise err=1 and stay in LOADN.
REQ-010 In LOADS, each load SHALL write din to sample[idx] and increment idx; when idx reaches n, go to READY.
REQ-011 clear SHALL, in any non-busy state, zero idx and n, clear err/done, and go to LOADN; clear while busy is ignored.
REQ-012 start in READY or DONE SHALL clear done, assert busy next cycle, and enter ACCUM.
REQ-013 start in LOADN/LOADS SHALL set err=1 and not start; start while busy SHALL be ignored.
REQ-014 load while busy or in READY/DONE SHALL be ignored.
REQ-015 mode SHALL be latched on start; later mode changes do not affect the running computation.
REQ-016 ACCUM SHALL process one sample per cycle (n cycles): sum += x, sumsq += x*x, in RW-bit unsigned arithmetic with no overflow possible.
REQ-017 Mode 00/10 SHALL go from ACCUM to DONE with result = sum/sumsq; latency from start to done = n+2 cycles.
REQ-018 Mode 01/11 SHALL run a restoring divider, one quotient bit per cycle (RW cycles), giving avg = floor(sum/n).
REQ-019 Mode 11 SHALL then run VAR (n cycles) accumulating |x-avg|^2, divide by n (RW cycles), and run SQRT, one result bit per cycle (ceil(RW/2) cycles), giving result = floor(sqrt(floor(var/n))).
REQ-020 busy SHALL be 1 from the cycle after start until done rises; done SHALL stay 1 until the next start, clear, or reset.
REQ-021 dout SHALL be combinationally result[8*byte_sel +: 8], zero-extended above RW; byte_sel >= NB gives 0x00.
REQ-022 result SHALL hold its value until the next computation completes; result is 0 before the first completion.

Reset
REQ-023 RESET SHALL asynchronously force IDLE, n=0, idx=0, result=0, busy=0, done=0, err=0, and dout=0x00.
REQ-024 RESET mid-computation SHALL abort it with no partial result visible; sample storage contents are don't-care after reset.

Structure
REQ-025 The shared package stats_pkg SHALL hold the mode encoding enum, the FSM state enum, and a clog2 function.
REQ-026 The integer square root SHALL be a sub-module stats_isqrt (start/done handshake, RW-bit input), reused by stats_engine.
REQ-027 Sample storage SHALL be a DEPTH x W register array; the divider SHALL be inline in stats_engine and shared between the average and variance divisions.

Verification
REQ-028 n=4, samples 1,2,3,4: mode 00 -> 10 (0x0A); 01 -> 2; 10 -> 30 (0x1E); 11 -> 1 (var=6/4=1).
REQ-029 n=10, all samples 31: mode 00 -> 310, byte0=0x36, byte1=0x01; mode 10 -> 9610, byte0=0x8A, byte1=0x25; mode 11 -> 0.
REQ-030 Load n=0 -> err=1, FSM stays in LOADN; load n=11 (DEPTH=10) -> err=1; start before all samples are loaded -> err=1, no busy.
REQ-031 Assert RESET during the SQRT phase -> busy=0, done=0, dout=0x00 immediately; reload and rerun reproduces REQ-028 values.
REQ-032 Pulse start again while busy and change mode mid-run -> the original result and latency are unchanged (mode 00, n=4: done 6 cycles after start).
REQ-033 Rerun with W=8, DEPTH=64: 64 samples of 255 -> sum 16320 (0x3FC0), std 0; byte_sel=NB -> 0x00.
